// File: rtl/receive_fsm.sv
// -----------------------------------------------------------------------------
// receive_fsm
//
// Receive-side sequencer for one ultrasound A-line. It is armed before a
// firing and starts its timeline when transmit_complete asserts. After a
// programmable blanking interval it captures num_samples echo ADC samples
// into an internal first-word-fall-through FIFO. The samples are streamed out
// over a valid/ready interface. It then pulses next_aline to release the
// transmitter.
//
// Ports:
//   clk                 system clock, all logic on posedge
//   rst                 asynchronous active-low reset
//   arm                 IDLE -> ARMED request (level)
//   abort               forces IDLE and flushes the FIFO (level)
//   transmit_complete   starts the receive timeline (level)
//   blank_count         cycles discarded after the trigger (latched at trigger)
//   num_samples         samples per A-line (latched at trigger)
//   adc_data/adc_valid  echo sample input
//   m_data/m_valid/m_last/m_ready  sample stream output (FIFO head)
//   receive_in_progress high in BLANK, ACQUIRE and DRAIN
//   aline_done          one-cycle pulse in DONE
//   next_aline          one-cycle pulse, coincident with aline_done
//   overflow            sticky: a sample was dropped on a full FIFO
// -----------------------------------------------------------------------------
module receive_fsm #(
    parameter int SAMPLE_WIDTH   = 12,
    parameter int COUNT_NUM_BITS = 16,
    parameter int FIFO_AW        = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      transmit_complete,
    input  logic [COUNT_NUM_BITS-1:0] blank_count,
    input  logic [COUNT_NUM_BITS-1:0] num_samples,
    input  logic [SAMPLE_WIDTH-1:0]   adc_data,
    input  logic                      adc_valid,
    output logic [SAMPLE_WIDTH-1:0]   m_data,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      receive_in_progress,
    output logic                      aline_done,
    output logic                      next_aline,
    output logic                      overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [COUNT_NUM_BITS-1:0] CNT_ZERO = {COUNT_NUM_BITS{1'b0}};
    localparam logic [COUNT_NUM_BITS-1:0] CNT_ONE  = {{(COUNT_NUM_BITS-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]          PTR_ZERO = {(FIFO_AW+1){1'b0}};
    localparam logic [FIFO_AW:0]          PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_BLANK   = 3'd2,
        S_ACQUIRE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [COUNT_NUM_BITS-1:0] r_blank_cnt;
    logic [COUNT_NUM_BITS-1:0] r_num;
    logic [COUNT_NUM_BITS-1:0] r_samp_cnt;
    logic [COUNT_NUM_BITS-1:0] w_samp_cnt_inc;

    // FIFO entry = {last tag, sample}
    logic [SAMPLE_WIDTH:0]     r_mem [DEPTH];
    logic [FIFO_AW:0]          r_wptr;
    logic [FIFO_AW:0]          r_rptr;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_acq_sample;
    logic                      w_wr;
    logic                      w_drop;
    logic                      w_last_sample;
    logic                      r_overflow;
    logic                      r_rip;
    logic                      r_done;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]) &&
                     (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]);
    assign w_pop   = ~w_empty & m_ready;

    // A sample only counts in ACQUIRE and never in the cycle abort wins.
    assign w_acq_sample   = (r_state == S_ACQUIRE) & adc_valid & ~abort;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_wr           = w_acq_sample & (~w_full | w_pop);
    assign w_drop         = w_acq_sample & w_full & ~w_pop;
    assign w_samp_cnt_inc = r_samp_cnt + CNT_ONE;
    assign w_last_sample  = w_acq_sample & (w_samp_cnt_inc == r_num);

    // Head of FIFO is forced to zero while empty so outputs are clean at reset.
    assign m_valid             = ~w_empty;
    assign m_data              = w_empty ? {SAMPLE_WIDTH{1'b0}} : r_mem[r_rptr[FIFO_AW-1:0]][SAMPLE_WIDTH-1:0];
    assign m_last              = w_empty ? 1'b0 : r_mem[r_rptr[FIFO_AW-1:0]][SAMPLE_WIDTH];
    assign receive_in_progress = r_rip;
    assign aline_done          = r_done;
    assign next_aline          = r_done;
    assign overflow            = r_overflow;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) w_next_state = S_ARMED;
                    else     w_next_state = S_IDLE;
                end
                S_ARMED: begin
                    if (!transmit_complete)                                  w_next_state = S_ARMED;
                    else if (blank_count == CNT_ZERO && num_samples == CNT_ZERO) w_next_state = S_DRAIN;
                    else if (blank_count == CNT_ZERO)                        w_next_state = S_ACQUIRE;
                    else                                                     w_next_state = S_BLANK;
                end
                S_BLANK: begin
                    // Nothing to acquire when num_samples is zero: skip straight to DRAIN.
                    if (r_blank_cnt != CNT_ONE) w_next_state = S_BLANK;
                    else if (r_num == CNT_ZERO) w_next_state = S_DRAIN;
                    else                        w_next_state = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    if (w_last_sample) w_next_state = S_DRAIN;
                    else               w_next_state = S_ACQUIRE;
                end
                S_DRAIN: begin
                    if (w_empty) w_next_state = S_DONE;
                    else         w_next_state = S_DRAIN;
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Blanking and sample counters, latched on the trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blank_cnt <= CNT_ZERO;
            r_num       <= CNT_ZERO;
            r_samp_cnt  <= CNT_ZERO;
        end else if (abort) begin
            r_blank_cnt <= r_blank_cnt;
            r_num       <= r_num;
            r_samp_cnt  <= r_samp_cnt;
        end else if (r_state == S_ARMED && transmit_complete) begin
            r_blank_cnt <= blank_count;
            r_num       <= num_samples;
            r_samp_cnt  <= CNT_ZERO;
        end else if (r_state == S_BLANK) begin
            r_blank_cnt <= r_blank_cnt - CNT_ONE;
        end else if (w_acq_sample) begin
            r_samp_cnt  <= w_samp_cnt_inc;
        end else begin
            r_samp_cnt  <= r_samp_cnt;
        end
    end

    // FIFO pointers; abort empties the FIFO by resetting both pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= PTR_ZERO;
            r_rptr <= PTR_ZERO;
        end else if (abort) begin
            r_wptr <= PTR_ZERO;
            r_rptr <= PTR_ZERO;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= {w_last_sample, adc_data};
    end

    // Registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rip      <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rip  <= (w_next_state == S_BLANK) || (w_next_state == S_ACQUIRE) ||
                      (w_next_state == S_DRAIN);
            r_done <= (w_next_state == S_DONE);
            if (!abort && r_state == S_IDLE && arm) r_overflow <= 1'b0;
            else if (w_drop)                        r_overflow <= 1'b1;
            else                                    r_overflow <= r_overflow;
        end
    end

endmodule
